// File: rtl/td_mac_pkg.sv
// Shared types and time-base constants for the time-domain MAC blocks.
package td_mac_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        OUTPUT  = 2'd2
    } td_state_e;

    // Cycles per DTC count step; common time base with the other DTC/TDC blocks.
    localparam int unsigned DEL_UNIT = 1;

endpackage

// File: rtl/td_mac_lane.sv
// One DTC/TDC lane: down-counter pulse generator gating its coefficient
// into the shared adder tree while the pulse is active.
module td_mac_lane
    import td_mac_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] x_i,
    input  logic [WIDTH-1:0] w_i,
    output logic [WIDTH-1:0] contrib_o,
    output logic             done_next_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] coef_q, coef_d;
    logic             active;

    assign active = (cnt_q != '0);

    always_comb begin
        cnt_d  = cnt_q;
        coef_d = coef_q;
        if (load_i) begin
            cnt_d  = x_i;
            coef_d = w_i;
        end else if (step_i && active) begin
            cnt_d = cnt_q - WIDTH'(DEL_UNIT);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            coef_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            coef_q <= coef_d;
        end
    end

    assign contrib_o   = active ? coef_q : '0;
    // Count reaches zero after this step (or is already zero).
    assign done_next_o = (cnt_q <= WIDTH'(DEL_UNIT));

endmodule

// File: rtl/td_mac_array.sv
// Multi-lane time-domain MAC: lanes integrate their coefficients for x_i
// cycles into a persistent saturating accumulator, with valid/ready on both sides.
module td_mac_array
    import td_mac_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NCH   = 4,
    parameter int unsigned ACC_W = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH*WIDTH-1:0] in_coeff,
    input  logic                 acc_clr,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_W-1:0]     out_data,
    output logic                 out_sat
);

    localparam int unsigned SUM_W = WIDTH + $clog2(NCH + 1);
    localparam int unsigned EXT_W = ((SUM_W > ACC_W) ? SUM_W : ACC_W) + 1;

    td_state_e        state_q;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             sat_q;
    logic             ovf;
    logic             load, step, all_done_next;
    logic [SUM_W-1:0] lane_sum;
    logic [EXT_W-1:0] sum_ext;
    logic [WIDTH-1:0] contrib [NCH];
    logic [NCH-1:0]   done_next;

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == OUTPUT);
    assign out_data  = acc_q;
    assign out_sat   = sat_q;

    assign load = in_ready && in_valid;
    assign step = (state_q == CONVERT);

    for (genvar i = 0; i < NCH; i++) begin : g_lane
        td_mac_lane #(.WIDTH(WIDTH)) u_lane (
            .clk        (clk),
            .rst        (rst),
            .load_i     (load),
            .step_i     (step),
            .x_i        (in_data[i*WIDTH +: WIDTH]),
            .w_i        (in_coeff[i*WIDTH +: WIDTH]),
            .contrib_o  (contrib[i]),
            .done_next_o(done_next[i])
        );
    end

    assign all_done_next = &done_next;

    always_comb begin
        lane_sum = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            lane_sum = lane_sum + SUM_W'(contrib[i]);
        end
    end

    // Add at a width that cannot wrap; any bit above ACC_W means overflow.
    always_comb begin
        sum_ext = EXT_W'(acc_q) + EXT_W'(lane_sum);
        ovf     = |sum_ext[EXT_W-1:ACC_W];
        acc_d   = ovf ? '1 : sum_ext[ACC_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        if (acc_clr) begin
                            acc_q <= '0;
                            sat_q <= 1'b0;
                        end
                        state_q <= CONVERT;
                    end
                end
                CONVERT: begin
                    acc_q <= acc_d;
                    sat_q <= sat_q | ovf;
                    if (all_done_next) begin
                        state_q <= OUTPUT;
                    end
                end
                OUTPUT: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
